// File: rtl/refcpu_bus_responder_if.sv
// ---------------------------------------------------------------------------
// refcpu_bus_responder_if
//
// Bundles the CPU instruction-bus (ibus) and data-bus (dbus) handshakes seen
// by the memory responder.
//
//   ibus : i_valid, i_addr            (CPU -> memory)
//          i_addr_ok, i_data_ok, i_data (memory -> CPU)
//   dbus : d_valid, d_addr, d_size, d_strobe, d_wdata (CPU -> memory)
//          d_addr_ok, d_data_ok, d_data               (memory -> CPU)
//
// Modports:
//   master : the CPU side (drives requests, receives responses)
//   slave  : the memory side (refcpu_bus_responder)
// ---------------------------------------------------------------------------
interface refcpu_bus_responder_if;
    // ibus
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_data;

    // dbus
    logic        d_valid;
    logic [31:0] d_addr;
    logic [2:0]  d_size;
    logic [3:0]  d_strobe;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_data;

    modport master (
        output i_valid, i_addr,
        input  i_addr_ok, i_data_ok, i_data,
        output d_valid, d_addr, d_size, d_strobe, d_wdata,
        input  d_addr_ok, d_data_ok, d_data
    );

    modport slave (
        input  i_valid, i_addr,
        output i_addr_ok, i_data_ok, i_data,
        input  d_valid, d_addr, d_size, d_strobe, d_wdata,
        output d_addr_ok, d_data_ok, d_data
    );
endinterface

// File: rtl/refcpu_bus_responder.sv
// ---------------------------------------------------------------------------
// refcpu_bus_responder
//
// Memory-side responder for the CPU ibus and dbus. Each bus may have one
// request outstanding. Requests are served from a single-port word array:
// the word is read (and, for dbus writes, byte-merged) in the accept cycle,
// and the read word is returned LATENCY cycles later as a one-cycle
// data_ok pulse. dbus writes return the word as it was before the write.
//
// Parameters:
//   MEM_WORDS : array depth in 32-bit words (power of 2)
//   LATENCY   : cycles from accept to data_ok, 1..15
//
// Ports:
//   clk    : clock
//   resetn : synchronous active-low reset (array contents are kept)
//   bus    : ibus/dbus handshake bundle, slave side
//            x_addr_ok - request accepted this cycle (combinational)
//            x_data_ok - response pulse, x_data valid only in that cycle
//            d_strobe  - byte write enables, 0 means read
//            d_size    - informational only, ignored
// ---------------------------------------------------------------------------
module refcpu_bus_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    refcpu_bus_responder_if.slave bus
);

    localparam int         AW       = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      i_state, i_state_nx;
    state_t      d_state, d_state_nx;
    logic [3:0]  i_cnt, i_cnt_nx;
    logic [3:0]  d_cnt, d_cnt_nx;
    logic [31:0] i_resp, d_resp;

    logic [31:0] mem [MEM_WORDS];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic          i_done, d_done;
    logic          i_free, d_free;
    logic          i_grant, d_grant;
    logic          i_accept, d_accept;
    logic [AW-1:0] i_idx, d_idx, acc_idx;
    logic [31:0]   rd_word;

    // Word index: byte offset dropped, high bits dropped so addresses wrap.
    assign i_idx = bus.i_addr[AW+1:2];
    assign d_idx = bus.d_addr[AW+1:2];

    // The response cycle is also a free cycle: a new request can be taken
    // while the previous one's data_ok is on the bus.
    assign i_done = (i_state == ST_BUSY) && (i_cnt == 4'd0);
    assign d_done = (d_state == ST_BUSY) && (d_cnt == 4'd0);
    assign i_free = (i_state == ST_IDLE) || i_done;
    assign d_free = (d_state == ST_IDLE) || d_done;

    // One array port, so at most one accept per cycle; dbus wins ties.
    assign d_grant = d_free;
    assign i_grant = i_free && !(bus.d_valid && d_free);

    // resetn gates acceptance so nothing is taken (or written) during reset.
    assign d_accept = resetn && bus.d_valid && d_grant;
    assign i_accept = resetn && bus.i_valid && i_grant;

    assign acc_idx = d_accept ? d_idx : i_idx;
    assign rd_word = mem[acc_idx];

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.i_addr_ok = i_accept;
    assign bus.d_addr_ok = d_accept;
    assign bus.i_data_ok = resetn && i_done;
    assign bus.d_data_ok = resetn && d_done;
    assign bus.i_data    = i_resp;
    assign bus.d_data    = d_resp;

    // Address bits outside the word index and d_size carry no function here.
    logic unused_inputs;
    assign unused_inputs = ^{bus.i_addr[31:AW+2], bus.i_addr[1:0],
                             bus.d_addr[31:AW+2], bus.d_addr[1:0],
                             bus.d_size};

    // -----------------------------------------------------------------------
    // Next-state logic for both bus FSMs
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        i_state_nx = i_state;
        i_cnt_nx   = i_cnt;
        d_state_nx = d_state;
        d_cnt_nx   = d_cnt;

        unique case (i_state)
            ST_IDLE: begin
                if (i_accept) begin
                    i_state_nx = ST_BUSY;
                    i_cnt_nx   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (i_cnt != 4'd0) begin
                    i_cnt_nx = i_cnt - 4'd1;
                end else if (i_accept) begin
                    i_cnt_nx = CNT_LOAD;
                end else begin
                    i_state_nx = ST_IDLE;
                end
            end
            default: begin
                i_state_nx = ST_IDLE;
                i_cnt_nx   = 4'd0;
            end
        endcase

        unique case (d_state)
            ST_IDLE: begin
                if (d_accept) begin
                    d_state_nx = ST_BUSY;
                    d_cnt_nx   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (d_cnt != 4'd0) begin
                    d_cnt_nx = d_cnt - 4'd1;
                end else if (d_accept) begin
                    d_cnt_nx = CNT_LOAD;
                end else begin
                    d_state_nx = ST_IDLE;
                end
            end
            default: begin
                d_state_nx = ST_IDLE;
                d_cnt_nx   = 4'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and response registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            i_state <= ST_IDLE;
            d_state <= ST_IDLE;
            i_cnt   <= 4'd0;
            d_cnt   <= 4'd0;
            i_resp  <= '0;
            d_resp  <= '0;
        end else begin
            i_state <= i_state_nx;
            d_state <= d_state_nx;
            i_cnt   <= i_cnt_nx;
            d_cnt   <= d_cnt_nx;
            // rd_word is the pre-edge array content, which gives
            // read-before-write on dbus writes.
            if (i_accept) i_resp <= rd_word;
            if (d_accept) d_resp <= rd_word;
        end
    end

    // -----------------------------------------------------------------------
    // Word array
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset; its contents survive resetn and are
    // only loaded through dbus writes or a bench backdoor.
    always_ff @(posedge clk) begin
        if (d_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.d_strobe[b]) begin
                    mem[d_idx][8*b +: 8] <= bus.d_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_refcpu_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_refcpu_bus_responder
//
// Two responders share clk/resetn: dut0 with LATENCY=2, dut1 with LATENCY=1,
// both MEM_WORDS=1024. A scoreboard pushes the expected word and response
// cycle on every observed accept (from a bench-side memory model) and pops
// them on every data_ok. A table of single transactions and a few
// hand-written multi-cycle sequences provide the stimulus.
// ---------------------------------------------------------------------------
module tb_refcpu_bus_responder;

    typedef struct {
        int          u;
        bit          is_d;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    typedef struct {
        int          u;
        bit          is_d;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    logic        iv [2];
    logic [31:0] ia [2];
    logic        dv [2];
    logic [31:0] da [2];
    logic [3:0]  ds [2];
    logic [31:0] dw [2];
    logic        iaok [2];
    logic        idok [2];
    logic        daok [2];
    logic        ddok [2];
    logic [31:0] idat [2];
    logic [31:0] ddat [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] model [2][1024];
    sb_t         sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    refcpu_bus_responder_if bus0();
    refcpu_bus_responder_if bus1();

    assign bus0.i_valid  = iv[0];
    assign bus0.i_addr   = ia[0];
    assign bus0.d_valid  = dv[0];
    assign bus0.d_addr   = da[0];
    assign bus0.d_size   = 3'd2;
    assign bus0.d_strobe = ds[0];
    assign bus0.d_wdata  = dw[0];
    assign iaok[0] = bus0.i_addr_ok;
    assign idok[0] = bus0.i_data_ok;
    assign idat[0] = bus0.i_data;
    assign daok[0] = bus0.d_addr_ok;
    assign ddok[0] = bus0.d_data_ok;
    assign ddat[0] = bus0.d_data;

    assign bus1.i_valid  = iv[1];
    assign bus1.i_addr   = ia[1];
    assign bus1.d_valid  = dv[1];
    assign bus1.d_addr   = da[1];
    assign bus1.d_size   = 3'd2;
    assign bus1.d_strobe = ds[1];
    assign bus1.d_wdata  = dw[1];
    assign iaok[1] = bus1.i_addr_ok;
    assign idok[1] = bus1.i_data_ok;
    assign idat[1] = bus1.i_data;
    assign daok[1] = bus1.d_addr_ok;
    assign ddok[1] = bus1.d_data_ok;
    assign ddat[1] = bus1.d_data;

    refcpu_bus_responder #(.MEM_WORDS(1024), .LATENCY(2)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    refcpu_bus_responder #(.MEM_WORDS(1024), .LATENCY(1)) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic backdoor(input int u, input int idx, input logic [31:0] v);
        if (u == 0) dut0.mem[idx] <= v;
        else        dut1.mem[idx] <= v;
        model[u][idx] = v;
    endtask

    task automatic sb_pop(input int u, input bit is_d, input logic [31:0] data);
        int hit;
        hit = -1;
        for (int k = 0; k < sb.size(); k++) begin
            if (hit < 0 && sb[k].u == u && sb[k].is_d == is_d) hit = k;
        end
        if (hit < 0) begin
            total++;
            bad++;
            $display("FAIL unexpected %s_data_ok u%0d: got pulse expected none (cycle %0d)",
                     is_d ? "d" : "i", u, cyc);
        end else begin
            check($sformatf("%s_data u%0d", is_d ? "d" : "i", u), data, sb[hit].data);
            check($sformatf("%s_data_ok cycle u%0d", is_d ? "d" : "i", u), cyc, sb[hit].cyc);
            sb.delete(hit);
        end
    endtask

    task automatic mon(input int u);
        int lat;
        lat = (u == 0) ? 2 : 1;
        if (!resetn) begin
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].u == u) sb.delete(k);
            end
            return;
        end
        if (idok[u]) sb_pop(u, 1'b0, idat[u]);
        if (ddok[u]) sb_pop(u, 1'b1, ddat[u]);
        if (iv[u] && iaok[u]) begin
            sb.push_back(sb_t'{u: u, is_d: 1'b0, data: model[u][ia[u][11:2]], cyc: cyc + lat});
        end
        if (dv[u] && daok[u]) begin
            sb.push_back(sb_t'{u: u, is_d: 1'b1, data: model[u][da[u][11:2]], cyc: cyc + lat});
            for (int b = 0; b < 4; b++) begin
                if (ds[u][b]) model[u][da[u][11:2]][8*b +: 8] = dw[u][8*b +: 8];
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Single request: drive, wait for accept, drop valid, wait for data_ok.
    task automatic txn(input int u, input bit is_d, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wdata,
                       output logic [31:0] rdata, output bit ok);
        bit got;
        rdata = '0;
        ok    = 1'b0;
        @(posedge clk); #1;
        if (is_d) begin
            dv[u] = 1'b1; da[u] = addr; ds[u] = strb; dw[u] = wdata;
        end else begin
            iv[u] = 1'b1; ia[u] = addr;
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = is_d ? daok[u] : iaok[u];
        end
        @(posedge clk); #1;
        dv[u] = 1'b0;
        iv[u] = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL accept timeout u%0d addr %08h: got no addr_ok expected one", u, addr);
            return;
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (k > 0 || u != 1) @(negedge clk);
            else @(negedge clk);
            if (is_d ? ddok[u] : idok[u]) begin
                got   = 1'b1;
                rdata = is_d ? ddat[u] : idat[u];
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL response timeout u%0d addr %08h: got no data_ok expected one", u, addr);
            return;
        end
        ok = 1'b1;
    endtask

    // Hold i_valid for n cycles and count accepts and data_ok pulses.
    task automatic b2b(input int u, input int n, input int exp_cnt);
        int acc;
        int dok;
        acc = 0;
        dok = 0;
        @(posedge clk); #1;
        iv[u] = 1'b1;
        ia[u] = 32'h14;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (iaok[u]) acc++;
            if (idok[u]) dok++;
        end
        @(posedge clk); #1;
        iv[u] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (idok[u]) dok++;
        end
        check($sformatf("b2b accepts u%0d", u), acc, exp_cnt);
        check($sformatf("b2b data_ok pulses u%0d", u), dok, exp_cnt);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    vec_t vecs [12];

    initial begin
        logic [31:0] rd;
        bit          ok;
        int          t_acc, d_cyc, i_cyc, cnt;
        logic [31:0] d_word, i_word;

        for (int u = 0; u < 2; u++) begin
            iv[u] = 1'b1; ia[u] = '0;
            dv[u] = 1'b1; da[u] = '0; ds[u] = '0; dw[u] = '0;
        end

        for (int u = 0; u < 2; u++) begin
            backdoor(u, 1,  32'hCAFEF00D);
            backdoor(u, 2,  32'h12345678);
            backdoor(u, 3,  32'h11223344);
            backdoor(u, 5,  32'hDEADBEEF);
            backdoor(u, 8,  32'h00000000);
            backdoor(u, 16, 32'h00000000);
            backdoor(u, 32, 32'h00000000);
        end

        // Strobe 4'b0101 takes bytes 0 and 2 from wdata.
        vecs[0]  = '{0, 1'b0, 32'h0000_0014, 4'h0, 32'h0,          32'hDEADBEEF};
        vecs[1]  = '{0, 1'b1, 32'h0000_000C, 4'h5, 32'hAABBCCDD,   32'h11223344};
        vecs[2]  = '{0, 1'b1, 32'h0000_000C, 4'h0, 32'h0,          32'h11BB33DD};
        vecs[3]  = '{0, 1'b0, 32'h0000_1004, 4'h0, 32'h0,          32'hCAFEF00D};
        vecs[4]  = '{0, 1'b1, 32'h0000_0040, 4'hF, 32'h24000001,   32'h00000000};
        vecs[5]  = '{0, 1'b0, 32'h0000_0040, 4'h0, 32'h0,          32'h24000001};
        vecs[6]  = '{0, 1'b1, 32'h0000_000E, 4'h8, 32'h77000000,   32'h11BB33DD};
        vecs[7]  = '{0, 1'b0, 32'h0000_000C, 4'h0, 32'h0,          32'h77BB33DD};
        vecs[8]  = '{0, 1'b1, 32'h0000_400C, 4'h0, 32'h0,          32'h77BB33DD};
        vecs[9]  = '{1, 1'b0, 32'h0000_1004, 4'h0, 32'h0,          32'hCAFEF00D};
        vecs[10] = '{1, 1'b1, 32'h0000_0008, 4'h3, 32'h0000BEEF,   32'h12345678};
        vecs[11] = '{1, 1'b0, 32'h0000_0008, 4'h0, 32'h0,          32'h1234BEEF};

        // Reset with requests held: everything reads 0 after the reset edge.
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset i_addr_ok u%0d", u), iaok[u], 1'b0);
            check($sformatf("reset d_addr_ok u%0d", u), daok[u], 1'b0);
            check($sformatf("reset i_data_ok u%0d", u), idok[u], 1'b0);
            check($sformatf("reset d_data_ok u%0d", u), ddok[u], 1'b0);
            check($sformatf("reset i_data u%0d", u), idat[u], 32'h0);
            check($sformatf("reset d_data u%0d", u), ddat[u], 32'h0);
        end
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            iv[u] = 1'b0;
            dv[u] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Table of single transactions.
        for (int k = 0; k < 12; k++) begin
            txn(vecs[k].u, vecs[k].is_d, vecs[k].addr, vecs[k].strb, vecs[k].wdata, rd, ok);
            if (ok) check($sformatf("vec%0d", k), rd, vecs[k].exp);
        end

        // Contention plus write-then-fetch: dbus write wins, ibus is taken
        // the next cycle and must see the written word.
        @(posedge clk); #1;
        dv[0] = 1'b1; da[0] = 32'h80; ds[0] = 4'hF; dw[0] = 32'h24000002;
        iv[0] = 1'b1; ia[0] = 32'h80;
        @(negedge clk);
        t_acc = cyc;
        check("contend d_addr_ok", daok[0], 1'b1);
        check("contend i_addr_ok", iaok[0], 1'b0);
        @(posedge clk); #1;
        dv[0] = 1'b0;
        @(negedge clk);
        check("retry i_addr_ok", iaok[0], 1'b1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        d_cyc = -1; i_cyc = -1; d_word = '0; i_word = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ddok[0]) begin d_cyc = cyc; d_word = ddat[0]; end
            if (idok[0]) begin i_cyc = cyc; i_word = idat[0]; end
        end
        check("contend d_data_ok cycle", d_cyc, t_acc + 2);
        check("contend i after d", i_cyc, d_cyc + 1);
        check("contend old word", d_word, 32'h00000000);
        check("fetch after write", i_word, 32'h24000002);

        // Back-to-back with i_valid held.
        b2b(0, 8, 4);
        b2b(1, 8, 8);

        // Reset mid-transaction: the write sticks, the response is dropped.
        @(posedge clk); #1;
        dv[0] = 1'b1; da[0] = 32'h20; ds[0] = 4'hF; dw[0] = 32'h5A5A5A5A;
        @(negedge clk);
        check("pre-reset accept", daok[0], 1'b1);
        @(posedge clk); #1;
        dv[0]  = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ddok[0] || idok[0]) cnt++;
        end
        check("no data_ok after reset", cnt, 0);
        txn(0, 1'b0, 32'h20, 4'h0, 32'h0, rd, ok);
        if (ok) check("read after reset", rd, 32'h5A5A5A5A);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected one within 20000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
